if_id_skid_stage: RTL
=====================

// Module: if_id_skid_stage
// PURPOSE
//  Parametrised IF->ID pipeline register; successor to the fixed 8-bit PC / 20-bit instr IF/ID latch.
//  Replaces the single stall input with valid/ready handshakes on both sides.
//  A 2-entry skid buffer gives full throughput with registered ready.
//  Adds synchronous flush, field decode (opcode/A/B) of the held instr, and a saturating stall counter.
//  Sits between if_stage (upstream) and id_stage (downstream).
// PARAMETERS
//  PC_W   8   PC width
//  OPC_W  4   opcode field width
//  OPD_W  8   operand field width (A and B each); INSTR_W = OPC_W + 2*OPD_W (default 20)
//  CNT_W  16  stall counter width
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  flush      in   1        drop all held entries (branch/redirect)
//  in_valid   in   1        upstream entry valid
//  in_ready   out  1        stage can accept
//  in_pc      in   PC_W     upstream PC
//  in_instr   in   INSTR_W  upstream instruction
//  out_valid  out  1        downstream entry valid
//  out_ready  in   1        downstream accepts
//  out_pc     out  PC_W     held PC
//  out_instr  out  INSTR_W  held instruction
//  out_opcode out  OPC_W    out_instr[INSTR_W-1 -: OPC_W]
//  out_a      out  OPD_W    out_instr[2*OPD_W-1 -: OPD_W]
//  out_b      out  OPD_W    out_instr[OPD_W-1:0]
//  stall_cnt  out  CNT_W    cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  - Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Data moves only on fire.
//  - Registers: main {pc,instr} drives the outputs; skid {pc,instr} is the overflow entry.
//  - State machine (state: EMPTY, BUSY, FULL):
//    - EMPTY: in_fire -> load main, go BUSY.
//    - BUSY, in_fire & out_ready: main <= in, stay BUSY.
//    - BUSY, in_fire & !out_ready: skid <= in, go FULL.
//    - BUSY, !in_fire & out_ready: go EMPTY.
//    - FULL, out_ready: main <= skid, go BUSY.
//    - FULL, !out_ready: hold.
//  - Outputs: out_valid = (state != EMPTY). in_ready = !rst & !flush & (state != FULL).
//  - Latency: 1 cycle from in_fire to out_valid when EMPTY. Throughput: 1 entry/cycle.
//  - Ordering: strictly FIFO. An entry never duplicates or drops except on flush or rst.
//  - Flush: highest priority after rst. Next state is EMPTY and out_valid=0 next cycle.
//    - in_ready is 0 during the flush cycle, so no entry is accepted.
//    - An out_fire in the flush cycle still counts as consumed.
//    - Data registers keep their contents; only valid state clears.
//  - Reset (any cycle, incl. mid-transfer or FULL):
//    - state=EMPTY, out_valid=0, in_ready=0 while rst is high.
//    - main and skid data = 0, so out_pc/out_instr/out_opcode/out_a/out_b = 0.
//    - stall_cnt = 0.
//  - Hold: out_* stable while out_valid & !out_ready (AXI-style hold rule).
//  - stall_cnt: +1 per cycle with out_valid & !out_ready. Sticks at 2^CNT_W-1; cleared only by rst.
//    Flush does not clear it.
//  - Decode: pure bit slices of main.instr. Unsigned; no sign extension.
// STRUCTURE
//  - pipe_pkg holds:
//    - field-width localparams and a derived INSTR_W function;
//    - state encoding EMPTY=2'd0, BUSY=2'd1, FULL=2'd2 (2'd3 illegal -> EMPTY).
//  - One sub-module, sat_counter #(CNT_W) (clk, rst, inc, count), used for stall_cnt.
//  - Skid/main datapath and FSM stay in this module.
// TESTING
//  - Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, in_ready=0, out_* = 0, stall_cnt=0.
//  - Streaming: out_ready=1, send pc 0..9 back to back.
//    -> out_pc 0..9, one cycle after input, no gaps.
//    -> instr 20'hA1234 decodes to opcode=4'hA, A=8'h12, B=8'h34.
//  - Backpressure: send pc 5,6,7 with out_ready=0.
//    -> pc 5 in main, pc 6 in skid, in_ready=0, pc 7 held upstream.
//    -> Raise out_ready: out_pc 5,6,7 in order. stall_cnt equals the cycles stalled.
//  - Flush in FULL: pc 5/6 held, pulse flush with in_valid=1 pc 9.
//    -> in_ready=0 that cycle, out_valid=0 next cycle, pc 9 accepted the cycle after.
//  - Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15, stays 15.
//  - Mid-op reset in FULL -> next cycle EMPTY, outputs 0, no stale pc emitted afterwards.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, state encoding and width helper for the IF/ID skid stage
package pipe_pkg;

  localparam int DEF_PC_W  = 8;
  localparam int DEF_OPC_W = 4;
  localparam int DEF_OPD_W = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic int instr_w(input int opc_w, input int opd_w);
    return opc_w + 2 * opd_w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones, cleared only by reset
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - IF->ID register with valid/ready handshakes, 2-entry skid, flush and decode
module if_id_skid_stage
  import pipe_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int OPC_W = DEF_OPC_W,
  parameter int OPD_W = DEF_OPD_W,
  parameter int CNT_W = DEF_CNT_W,
  localparam int INSTR_W = instr_w(OPC_W, OPD_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [OPD_W-1:0]   out_a,
  output logic [OPD_W-1:0]   out_b,
  output logic [CNT_W-1:0]   stall_cnt
);

  state_t             state;
  logic [PC_W-1:0]    main_pc, skid_pc;
  logic [INSTR_W-1:0] main_instr, skid_instr;
  logic               in_fire;

  assign in_ready  = !rst && !flush && (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_pc    <= '0;
      main_instr <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (flush) begin
      // Only the valid state is dropped; data registers keep their contents.
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_pc    <= in_pc;
            main_instr <= in_instr;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_ready) begin
            main_pc    <= in_pc;
            main_instr <= in_instr;
          end else if (in_fire) begin
            skid_pc    <= in_pc;
            skid_instr <= in_instr;
            state      <= FULL;
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            main_pc    <= skid_pc;
            main_instr <= skid_instr;
            state      <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_pc     = main_pc;
  assign out_instr  = main_instr;
  assign out_opcode = main_instr[INSTR_W-1 -: OPC_W];
  assign out_a      = main_instr[2*OPD_W-1 -: OPD_W];
  assign out_b      = main_instr[OPD_W-1:0];

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

endmodule
